// File: rtl/conv_window_generator.sv
// conv_window_generator
//   Streaming sliding-window generator. Accepts one multi-channel pixel per
//   clk_en cycle in raster order and emits every FILTER_SIZE x FILTER_SIZE
//   window of an IMAGE_WIDTH x IMAGE_HEIGHT frame at step STRIDE.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   clk_en       pixel strobe; input_data consumed on each enabled edge
//   input_data   one pixel, channel 0 in the MSBs
//   window_data  registered window, element (r,c,ch) at slice
//                (r*F+c)*D_CHANNELS+ch counted from the MSB end
//   valid        window_data holds a new window this cycle
//   frame_done   pulses with the last window of a frame
module conv_window_generator #(
  parameter int D_WIDTH      = 8,
  parameter int D_CHANNELS   = 3,
  parameter int FILTER_SIZE  = 5,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 32,
  parameter int STRIDE       = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 clk_en,
  input  logic [D_CHANNELS*D_WIDTH-1:0]                        input_data,
  output logic [FILTER_SIZE*FILTER_SIZE*D_CHANNELS*D_WIDTH-1:0] window_data,
  output logic                                                 valid,
  output logic                                                 frame_done
);

  localparam int F        = FILTER_SIZE;
  localparam int PW       = D_CHANNELS * D_WIDTH;
  localparam int WW       = F * F * PW;
  localparam int CW       = $clog2(IMAGE_WIDTH);
  localparam int RW       = $clog2(IMAGE_HEIGHT);
  localparam int SW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  // Position of the final window; trailing rows/cols that do not fit a
  // full stride step are skipped.
  localparam int LAST_ROW = IMAGE_HEIGHT - 1 - ((IMAGE_HEIGHT - F) % STRIDE);
  localparam int LAST_COL = IMAGE_WIDTH - 1 - ((IMAGE_WIDTH - F) % STRIDE);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [SW-1:0] col_ph;
  logic [SW-1:0] row_ph;
  logic [CW-1:0] col_next;
  logic [RW-1:0] row_next;
  logic [SW-1:0] col_ph_next;
  logic [SW-1:0] row_ph_next;

  // line_buf[k] holds the row k+1 rows above the current one.
  logic [PW-1:0] line_buf [F-1][IMAGE_WIDTH];
  logic [PW-1:0] win      [F][F];
  logic [PW-1:0] win_next [F][F];
  logic [PW-1:0] new_col  [F];
  logic [WW-1:0] win_packed;

  logic col_last;
  logic row_last;
  logic emit;
  logic frame_end;

  // Position flags and window emit decision for the current pixel.
  always_comb begin
    col_last  = (col == CW'(IMAGE_WIDTH - 1));
    row_last  = (row == RW'(IMAGE_HEIGHT - 1));
    emit      = (row >= RW'(F - 1)) && (col >= CW'(F - 1)) &&
                (row_ph == {SW{1'b0}}) && (col_ph == {SW{1'b0}});
    frame_end = emit && (row == RW'(LAST_ROW)) && (col == CW'(LAST_COL));
  end

  // Next counter and stride-phase values. Phases stay at zero until the
  // first full window fits, then count down from STRIDE-1 so a zero phase
  // marks every STRIDE-th position.
  always_comb begin
    col_next    = col + CW'(1);
    row_next    = row;
    col_ph_next = col_ph;
    row_ph_next = row_ph;
    if (col_last) begin
      col_next    = {CW{1'b0}};
      col_ph_next = {SW{1'b0}};
      if (row_last) begin
        row_next    = {RW{1'b0}};
        row_ph_next = {SW{1'b0}};
      end else if (row < RW'(F - 1)) begin
        row_next    = row + RW'(1);
        row_ph_next = {SW{1'b0}};
      end else begin
        row_next    = row + RW'(1);
        row_ph_next = (row_ph == {SW{1'b0}}) ? SW'(STRIDE - 1) : row_ph - SW'(1);
      end
    end else if (col < CW'(F - 1)) begin
      col_ph_next = {SW{1'b0}};
    end else begin
      col_ph_next = (col_ph == {SW{1'b0}}) ? SW'(STRIDE - 1) : col_ph - SW'(1);
    end
  end

  // Position counters and stride phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= {CW{1'b0}};
      row    <= {RW{1'b0}};
      col_ph <= {SW{1'b0}};
      row_ph <= {SW{1'b0}};
    end else if (clk_en) begin
      col    <= col_next;
      row    <= row_next;
      col_ph <= col_ph_next;
      row_ph <= row_ph_next;
    end
  end

  // New right-hand column (top = oldest row) and shifted/packed window.
  always_comb begin
    for (int r = 0; r < F - 1; r++) begin
      new_col[r] = line_buf[F - 2 - r][col];
    end
    new_col[F-1] = input_data;
    win_packed = {WW{1'b0}};
    for (int r = 0; r < F; r++) begin
      for (int c = 0; c < F; c++) begin
        if (c == F - 1) begin
          win_next[r][c] = new_col[r];
        end else begin
          win_next[r][c] = win[r][c+1];
        end
        win_packed[WW - 1 - (r*F + c)*PW -: PW] = win_next[r][c];
      end
    end
  end

  // Line buffers and window shift register; contents are always rewritten
  // before they can reach window_data, so they carry no reset.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      line_buf[0][col] <= input_data;
      for (int k = 1; k < F - 1; k++) begin
        line_buf[k][col] <= line_buf[k-1][col];
      end
      for (int r = 0; r < F; r++) begin
        for (int c = 0; c < F; c++) begin
          win[r][c] <= win_next[r][c];
        end
      end
    end
  end

  // Registered outputs; window_data only changes when a window is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= 1'b0;
      frame_done  <= 1'b0;
      window_data <= {WW{1'b0}};
    end else begin
      valid      <= clk_en & emit;
      frame_done <= clk_en & frame_end;
      if (clk_en && emit) begin
        window_data <= win_packed;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_generator.sv
module tb_conv_window_generator;

  localparam int W = 8;
  localparam int H = 6;
  localparam int F = 3;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic [7:0]   in1;
  logic [23:0]  in3;
  logic [71:0]  wd1, wd2;
  logic [215:0] wd3;
  logic v1, v2, v3, fd1, fd2, fd3;

  always #5 clk = ~clk;

  conv_window_generator #(.D_WIDTH(8), .D_CHANNELS(1), .FILTER_SIZE(F),
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .input_data(in1),
    .window_data(wd1), .valid(v1), .frame_done(fd1));

  conv_window_generator #(.D_WIDTH(8), .D_CHANNELS(1), .FILTER_SIZE(F),
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .input_data(in1),
    .window_data(wd2), .valid(v2), .frame_done(fd2));

  conv_window_generator #(.D_WIDTH(8), .D_CHANNELS(3), .FILTER_SIZE(F),
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .STRIDE(1)) dut3 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .input_data(in3),
    .window_data(wd3), .valid(v3), .frame_done(fd3));

  int pass_cnt = 0;
  int total    = 0;

  // reference model state
  int mr, mc;            // position of next pixel in frame
  int wi1, wi2;          // windows emitted so far in this frame
  logic [71:0]  e1, e2;  // expected window_data (held between windows)
  logic [215:0] e3;
  logic ev1, ev2, efd1, efd2;
  bit frame_wrapped;
  int cnt1, cnt2, cnt3;  // observed valid pulses per frame

  task automatic check(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected window with top-left pixel (r0,c0), values row*W+col.
  function automatic logic [215:0] win_of(input int r0, input int c0, input bit three);
    logic [215:0] w;
    logic [7:0] pv;
    w = '0;
    for (int i = 0; i < F; i++) begin
      for (int j = 0; j < F; j++) begin
        pv = 8'((r0 + i) * W + c0 + j);
        if (three) w = (w << 24) | {192'd0, pv, pv + 8'd64, pv + 8'd128};
        else       w = (w << 8)  | {208'd0, pv};
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0; wi1 = 0; wi2 = 0;
    e1 = '0; e2 = '0; e3 = '0;
  endtask

  // One clock: drive a pixel (or idle), then compare all outputs.
  task automatic step(input bit en);
    logic [215:0] t;
    logic [7:0] pv;
    pv = 8'(mr * W + mc);
    clk_en = en;
    in1 = pv;
    in3 = {pv, pv + 8'd64, pv + 8'd128};
    @(posedge clk);
    #1;
    ev1 = 1'b0; ev2 = 1'b0; efd1 = 1'b0; efd2 = 1'b0;
    frame_wrapped = 1'b0;
    if (en) begin
      if (mr >= F - 1 && mc >= F - 1) begin
        ev1 = 1'b1;
        t = win_of(mr - F + 1, mc - F + 1, 1'b0);
        e1 = t[71:0];
        e3 = win_of(mr - F + 1, mc - F + 1, 1'b1);
        wi1++;
        efd1 = (wi1 == ((W - F) / 1 + 1) * ((H - F) / 1 + 1));
        if ((mr - F + 1) % 2 == 0 && (mc - F + 1) % 2 == 0) begin
          ev2 = 1'b1;
          e2 = t[71:0];
          wi2++;
          efd2 = (wi2 == ((W - F) / 2 + 1) * ((H - F) / 2 + 1));
        end
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) begin
          mr = 0; wi1 = 0; wi2 = 0;
          frame_wrapped = 1'b1;
        end
      end
    end
    cnt1 += int'(v1); cnt2 += int'(v2); cnt3 += int'(v3);
    check("valid_s1", {215'd0, v1}, {215'd0, ev1});
    check("frame_done_s1", {215'd0, fd1}, {215'd0, efd1});
    check("window_s1", {144'd0, wd1}, {144'd0, e1});
    check("valid_s2", {215'd0, v2}, {215'd0, ev2});
    check("frame_done_s2", {215'd0, fd2}, {215'd0, efd2});
    check("window_s2", {144'd0, wd2}, {144'd0, e2});
    check("valid_d3", {215'd0, v3}, {215'd0, ev1});
    check("frame_done_d3", {215'd0, fd3}, {215'd0, efd1});
    check("window_d3", wd3, e3);
    if (fd1) check("fd_topleft_s1", {208'd0, wd1[71:64]}, 216'd29);
    if (fd2) check("fd_topleft_s2", {208'd0, wd2[71:64]}, 216'd20);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_count_s1"}, 216'(cnt1), 216'd24);
    check({tag, "_count_s2"}, 216'(cnt2), 216'd6);
    check({tag, "_count_d3"}, 216'(cnt3), 216'd24);
    cnt1 = 0; cnt2 = 0; cnt3 = 0;
  endtask

  initial begin
    int guard;
    rst = 1'b1; clk_en = 1'b0; in1 = '0; in3 = '0;
    cnt1 = 0; cnt2 = 0; cnt3 = 0;
    model_reset();
    #3;
    check("reset_valid", {213'd0, v1, v2, v3}, 216'd0);
    check("reset_frame_done", {213'd0, fd1, fd2, fd3}, 216'd0);
    check("reset_window_s1", {144'd0, wd1}, 216'd0);
    check("reset_window_d3", wd3, 216'd0);
    #9 rst = 1'b0;

    // two frames back-to-back, clk_en held high
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W * H; i++) begin
        step(1'b1);
        if (i == 18) begin
          check("first_window_s1", {144'd0, wd1}, {144'd0, 72'h00_01_02_08_09_0A_10_11_12});
          check("first_window_d3_top", {192'd0, wd3[215:192]}, {192'd0, 24'h00_40_80});
        end
      end
      check_counts("frame");
    end

    // frame with clk_en toggling randomly
    guard = 0;
    do begin
      step(1'(($urandom % 2)));
      guard++;
    end while (!frame_wrapped && guard < 2000);
    check("random_frame_done_in_budget", 216'(frame_wrapped), 216'd1);
    check_counts("random");
    for (int i = 0; i < 4; i++) step(1'b0);

    // reset mid-frame after pixel 30
    for (int i = 0; i <= 30; i++) step(1'b1);
    cnt1 = 0; cnt2 = 0; cnt3 = 0;
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", {213'd0, v1, v2, v3}, 216'd0);
    check("midrst_frame_done", {213'd0, fd1, fd2, fd3}, 216'd0);
    check("midrst_window_s1", {144'd0, wd1}, 216'd0);
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < W * H; i++) step(1'b1);
    check_counts("after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
